// File: rtl/iq_sample_merger.sv
// rtl/iq_sample_merger.sv - merges interleaved I_lo/I_hi/Q_lo/Q_hi bytes into signed I/Q samples
module iq_sample_merger #(
  parameter int WIDTH      = 16,
  parameter int OFFSET_BIN = 1,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  input  logic             sync_i,
  output logic [WIDTH-1:0] i_o,
  output logic [WIDTH-1:0] q_o,
  output logic             merge_finished_o,
  output logic             start_o,
  output logic [7:0]       resync_cnt_o
);

  typedef enum logic [1:0] {
    S_ILO = 2'd0,
    S_IHI = 2'd1,
    S_QLO = 2'd2,
    S_QHI = 2'd3
  } state_t;

  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [15:0] MSB_FLIP     = (OFFSET_BIN != 0) ? 16'h8000 : 16'h0000;

  state_t      state;
  state_t      state_next;
  logic [7:0]  ilo_q;
  logic [7:0]  ihi_q;
  logic [7:0]  qlo_q;
  logic [7:0]  qhi_q;
  logic [7:0]  idle_cnt;
  logic        pending;
  logic        accept;
  logic        resync;
  logic        timeout_hit;
  logic        frame_done;
  logic        drop_counted;
  logic [15:0] i_word;
  logic [15:0] q_word;

  assign accept       = byte_valid_i & enable_i;
  assign resync       = accept & sync_i & (state != S_ILO);
  assign timeout_hit  = enable_i & ~accept & (state != S_ILO) & (idle_cnt == TIMEOUT_LAST);
  assign frame_done   = accept & ~sync_i & (state == S_QHI);
  assign drop_counted = resync | timeout_hit;
  assign i_word       = {ihi_q, ilo_q} ^ MSB_FLIP;
  assign q_word       = {qhi_q, qlo_q} ^ MSB_FLIP;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_ILO;
    end else begin
      state <= state_next;
    end
  end

  // A sync-flagged byte always restarts the frame, whatever state we were in.
  always_comb begin
    state_next = state;
    if (!enable_i) begin
      state_next = S_ILO;
    end else if (accept) begin
      if (sync_i) begin
        state_next = S_IHI;
      end else begin
        case (state)
          S_ILO:   state_next = S_IHI;
          S_IHI:   state_next = S_QLO;
          S_QLO:   state_next = S_QHI;
          default: state_next = S_ILO;
        endcase
      end
    end else if (timeout_hit) begin
      state_next = S_ILO;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ilo_q <= 8'h00;
      ihi_q <= 8'h00;
      qlo_q <= 8'h00;
      qhi_q <= 8'h00;
    end else if (accept) begin
      if (sync_i || state == S_ILO) begin
        ilo_q <= byte_i;
      end else if (state == S_IHI) begin
        ihi_q <= byte_i;
      end else if (state == S_QLO) begin
        qlo_q <= byte_i;
      end else begin
        qhi_q <= byte_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= 8'h00;
    end else if (!enable_i || accept || state == S_ILO || timeout_hit) begin
      idle_cnt <= 8'h00;
    end else begin
      idle_cnt <= idle_cnt + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resync_cnt_o <= 8'h00;
    end else if (drop_counted && resync_cnt_o != 8'hFF) begin
      resync_cnt_o <= resync_cnt_o + 8'h01;
    end
  end

  // Completed frame is staged one cycle so a falling enable can still cancel it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending          <= 1'b0;
      i_o              <= '0;
      q_o              <= '0;
      merge_finished_o <= 1'b0;
      start_o          <= 1'b0;
    end else if (!enable_i) begin
      pending          <= 1'b0;
      merge_finished_o <= 1'b0;
      start_o          <= 1'b0;
    end else begin
      pending          <= frame_done;
      merge_finished_o <= pending;
      if (pending) begin
        i_o     <= WIDTH'(i_word);
        q_o     <= WIDTH'(q_word);
        start_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_merger.sv
// tb/tb_iq_sample_merger.sv - scoreboard bench for iq_sample_merger
module tb_iq_sample_merger;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        sync_i;
  logic [15:0] i_o;
  logic [15:0] q_o;
  logic        merge_finished_o;
  logic        start_o;
  logic [7:0]  resync_cnt_o;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_pulse = -1;
  int          pulse_cnt = 0;
  bit          gap_check = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] last_exp = 32'h0;

  iq_sample_merger #(.WIDTH(16), .OFFSET_BIN(1), .TIMEOUT(255)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable_i),
    .byte_i           (byte_i),
    .byte_valid_i     (byte_valid_i),
    .sync_i           (sync_i),
    .i_o              (i_o),
    .q_o              (q_o),
    .merge_finished_o (merge_finished_o),
    .start_o          (start_o),
    .resync_cnt_o     (resync_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] i, input logic [15:0] q);
    return {i ^ 16'h8000, q ^ 16'h8000};
  endfunction

  task automatic send(input logic [7:0] b, input bit s);
    @(negedge clk);
    byte_valid_i = 1'b1;
    byte_i       = b;
    sync_i       = s;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      byte_valid_i = 1'b0;
      sync_i       = 1'b0;
      byte_i       = 8'($urandom);
    end
  endtask

  task automatic frame(input logic [15:0] i, input logic [15:0] q, input bit s, input bit expect_pulse);
    send(i[7:0], s);
    send(i[15:8], 1'b0);
    send(q[7:0], 1'b0);
    send(q[15:8], 1'b0);
    if (expect_pulse) sb.push_back(model(i, q));
  endtask

  // Every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (merge_finished_o) begin
      pulse_cnt++;
      check("pulse_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        last_exp = sb.pop_front();
        check("sample_iq", {i_o, q_o}, last_exp);
      end
      if (gap_check && last_pulse >= 0) check("pulse_gap", 32'(cyc - last_pulse), 32'd4);
      last_pulse = cyc;
    end
  end

  initial begin
    int p0;
    rst = 1'b1; enable_i = 1'b0; byte_valid_i = 1'b0; sync_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_i", 32'(i_o), 32'h0);
    check("rst_q", 32'(q_o), 32'h0);
    check("rst_pulse", 32'(merge_finished_o), 32'h0);
    check("rst_start", 32'(start_o), 32'h0);
    check("rst_resync", 32'(resync_cnt_o), 32'h0);
    rst = 1'b0; enable_i = 1'b1;

    // T1: offset-binary corner values and one-cycle latency
    send(8'h00, 1'b1); send(8'h80, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0);
    sb.push_back(32'h0000_7FFF);
    idle(1);
    check("t1_no_early_pulse", 32'(merge_finished_o), 32'h0);
    idle(1);
    check("t1_pulse", 32'(merge_finished_o), 32'h1);
    check("t1_i", 32'(i_o), 32'h0000);
    check("t1_q", 32'(q_o), 32'h7FFF);
    check("t1_start", 32'(start_o), 32'h1);
    frame(16'h0000, 16'hFFFF, 1'b0, 1'b1);
    idle(3);

    // T2: back-to-back random frames
    last_pulse = -1; gap_check = 1'b1; p0 = pulse_cnt;
    for (int n = 0; n < 1000; n++)
      frame(16'($urandom), 16'($urandom), bit'($urandom_range(0, 1)), 1'b1);
    idle(3);
    gap_check = 1'b0;
    check("t2_pulses", 32'(pulse_cnt - p0), 32'd1000);
    check("t2_resync", 32'(resync_cnt_o), 32'h0);

    // T3: mid-frame sync, then sync on the Q_hi slot
    send(8'h11, 1'b1); send(8'h22, 1'b0);
    frame(16'h4433, 16'h6655, 1'b1, 1'b1);
    idle(3);
    check("t3_resync", 32'(resync_cnt_o), 32'h1);
    send(8'hA1, 1'b1); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
    frame(16'hB2B1, 16'hB4B3, 1'b1, 1'b1);
    idle(3);
    check("t3_qhi_sync_resync", 32'(resync_cnt_o), 32'h2);

    // T4: 254 idle cycles survive, 255 time out
    send(8'hC1, 1'b1); send(8'hC2, 1'b0);
    idle(254);
    send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    sb.push_back(model(16'hC2C1, 16'hC4C3));
    idle(3);
    check("t4_no_timeout", 32'(resync_cnt_o), 32'h2);
    send(8'hD1, 1'b1); send(8'hD2, 1'b0);
    idle(255);
    frame(16'hE2E1, 16'hE4E3, 1'b0, 1'b1);
    idle(3);
    check("t4_timeout_resync", 32'(resync_cnt_o), 32'h3);

    // T5: enable drop with a completion pending, then mid-frame
    frame(16'hF2F1, 16'hF4F3, 1'b1, 1'b0);
    @(negedge clk); enable_i = 1'b0; byte_valid_i = 1'b0;
    @(negedge clk);
    check("t5_pending_suppressed", 32'(merge_finished_o), 32'h0);
    check("t5_start_low", 32'(start_o), 32'h0);
    check("t5_hold", {i_o, q_o}, model(16'hE2E1, 16'hE4E3));
    enable_i = 1'b1;
    send(8'h01, 1'b1); send(8'h02, 1'b0); send(8'h03, 1'b0);
    @(negedge clk); enable_i = 1'b0; byte_valid_i = 1'b1; byte_i = 8'h04; sync_i = 1'b0;
    @(negedge clk);
    check("t5_no_pulse", 32'(merge_finished_o), 32'h0);
    check("t5_start_off", 32'(start_o), 32'h0);
    enable_i = 1'b1; byte_valid_i = 1'b0;
    frame(16'h5A5A, 16'hA5A5, 1'b0, 1'b1);
    idle(3);
    check("t5_no_count", 32'(resync_cnt_o), 32'h3);
    check("t5_start_again", 32'(start_o), 32'h1);

    // T6: reset mid-frame
    send(8'h71, 1'b1); send(8'h72, 1'b0); send(8'h73, 1'b0);
    @(negedge clk); rst = 1'b1; byte_valid_i = 1'b0;
    @(negedge clk); @(negedge clk);
    check("t6_rst_i", 32'(i_o), 32'h0);
    check("t6_rst_q", 32'(q_o), 32'h0);
    check("t6_rst_pulse", 32'(merge_finished_o), 32'h0);
    check("t6_rst_start", 32'(start_o), 32'h0);
    check("t6_rst_resync", 32'(resync_cnt_o), 32'h0);
    rst = 1'b0;
    frame(16'h1234, 16'hFEDC, 1'b0, 1'b1);
    idle(3);
    check("t6_start", 32'(start_o), 32'h1);
    check("t6_resync", 32'(resync_cnt_o), 32'h0);

    idle(4);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
